// File: rtl/img_stream_tx.sv
// Frame-buffered raster pixel streamer: stores an Img_W x Img_H image, streams it on start (macro STREAM_ZERO_PAD_EN adds a zero border).
// Latency: first pixel valid two edges after the start-sampling edge (counting that edge); one pixel per cycle thereafter.
// Backpressure: valid/ready; a stalled pixel and its sof/eol/eof hold stable until out_ready accepts it.
module img_stream_tx #(
    parameter int Datawidth = 8,
    parameter int Img_W     = 512,
    parameter int Img_H     = 512
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(Img_W*Img_H)-1:0] wr_addr,
    input  logic [Datawidth-1:0]           wr_data,
    input  logic                           start,
    input  logic                           out_ready,
    output logic [Datawidth-1:0]           out_img_data,
    output logic                           img_valid,
    output logic                           sof,
    output logic                           eol,
    output logic                           eof,
    output logic                           busy,
    output logic                           done
);
    localparam int AW    = $clog2(Img_W*Img_H);
    localparam int Depth = Img_W*Img_H;
`ifdef STREAM_ZERO_PAD_EN
    localparam int FW = Img_W + 2;
    localparam int FH = Img_H + 2;
`else
    localparam int FW = Img_W;
    localparam int FH = Img_H;
`endif
    localparam int CW = (FW > 1) ? $clog2(FW) : 1;
    localparam int RW = (FH > 1) ? $clog2(FH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [Datawidth-1:0] pix_q, pix_d;
    logic [Datawidth-1:0] mem_q [Depth];

    logic                 fire;
    logic                 last;
    logic                 rd_en;
    logic [CW-1:0]        rd_col;
    logic [RW-1:0]        rd_row;
    logic [AW-1:0]        rd_addr;
`ifdef STREAM_ZERO_PAD_EN
    logic                 rd_zero;
`endif

    assign fire = (state_q == STREAM) && out_ready;
    assign last = (col_q == CW'(FW-1)) && (row_q == RW'(FH-1));

    // Frame buffer write port; the image is frozen while a frame is in flight.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // FSM sequencing and raster counters; the read always targets the pixel to present next.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        rd_en   = 1'b0;
        rd_col  = col_q;
        rd_row  = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            FETCH: begin
                state_d = STREAM;
                rd_en   = 1'b1;
                rd_col  = '0;
                rd_row  = '0;
            end
            STREAM: begin
                if (fire) begin
                    if (last) begin
                        state_d = DONE;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_q == CW'(FW-1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    rd_en  = 1'b1;
                    rd_col = col_d;
                    rd_row = row_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Map frame position to buffer address and load the prefetched pixel register.
    always_comb begin
        pix_d = pix_q;
`ifdef STREAM_ZERO_PAD_EN
        rd_zero = (rd_col == '0) || (rd_col == CW'(FW-1)) ||
                  (rd_row == '0) || (rd_row == RW'(FH-1));
        rd_addr = rd_zero ? '0 : AW'((int'(rd_row) - 1) * Img_W + int'(rd_col) - 1);
        if (rd_en) begin
            pix_d = rd_zero ? '0 : mem_q[rd_addr];
        end
`else
        rd_addr = AW'(int'(rd_row) * Img_W + int'(rd_col));
        if (rd_en) begin
            pix_d = mem_q[rd_addr];
        end
`endif
    end

    // State, counters and output pixel; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
        end
    end

    assign out_img_data = pix_q;
    assign img_valid    = (state_q == STREAM);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign sof          = img_valid && (col_q == '0) && (row_q == '0);
    assign eol          = img_valid && (col_q == CW'(FW-1));
    assign eof          = img_valid && last;

endmodule
